// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared defaults, FSM encoding and accumulator sizing for the
//               systolic matrix-multiply stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int c_def_d_w = 8;
    localparam int c_def_n   = 2;
    localparam int c_def_k   = 2;
    localparam int c_def_l   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Wide enough that K full-scale unsigned products never wrap.
    function automatic int acc_width(input int d_w, input int k);
        return 2 * d_w + $clog2(k);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_pe.sv
`default_nettype none
// ============================================================================
// Module      : pe
// Description : One mesh cell: forwards X east and Y south through a register
//               each, and accumulates x*y when both incoming operands are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module pe #(
    parameter int D_W   = 8,
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [D_W-1:0]   i_x,
    input  logic             i_x_vld,
    input  logic [D_W-1:0]   i_y,
    input  logic             i_y_vld,
    output logic [D_W-1:0]   o_x,
    output logic             o_x_vld,
    output logic [D_W-1:0]   o_y,
    output logic             o_y_vld,
    output logic [ACC_W-1:0] o_acc
);

    logic [D_W-1:0]   r_x;
    logic             r_x_vld;
    logic [D_W-1:0]   r_y;
    logic             r_y_vld;
    logic [ACC_W-1:0] r_acc;
    logic [2*D_W-1:0] w_prod;

    assign w_prod = {{D_W{1'b0}}, i_x} * {{D_W{1'b0}}, i_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_x_vld <= 1'b0;
            r_y     <= '0;
            r_y_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_x     <= i_x;
            r_x_vld <= i_x_vld;
            r_y     <= i_y;
            r_y_vld <= i_y_vld;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_x_vld && i_y_vld) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
        end
    end

    assign o_x     = r_x;
    assign o_x_vld = r_x_vld;
    assign o_y     = r_y;
    assign o_y_vld = r_y_vld;
    assign o_acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array
// Description : Output-stationary NxN MAC mesh computing C = A*B from skewed
//               row/column operand streams; holds the result and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array
    import tpu_pkg::*;
#(
    parameter  int D_W   = c_def_d_w,
    parameter  int N     = c_def_n,
    parameter  int K     = c_def_k,
    parameter  int L     = c_def_l,
    localparam int ACC_W = acc_width(D_W, K)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*D_W-1:0]     in_x_flat,
    input  logic [N*D_W-1:0]     in_y_flat,
    input  logic                 in_init,
    output logic [N*N*ACC_W-1:0] result_flat,
    output logic                 busy,
    output logic                 done
);

    // Counter value during the cycle whose closing edge is the last accumulate.
    localparam int c_last  = L + 2*N + K - 3;
    localparam int c_cnt_w = (c_last > 1) ? $clog2(c_last + 1) : 1;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               w_start;
    logic [31:0]        w_cnt32;
    logic [N-1:0]       w_lane_vld;

    logic [D_W-1:0]   w_x   [N][N+1];
    logic             w_xv  [N][N+1];
    logic [D_W-1:0]   w_y   [N+1][N];
    logic             w_yv  [N+1][N];
    logic [ACC_W-1:0] w_acc [N][N];

    assign w_start = in_init && (r_state != RUN);
    assign w_cnt32 = 32'(r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (r_cnt == c_cnt_w'(c_last)) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (in_init) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    // Row lane r and column lane r share the same skewed validity window.
    generate
        for (genvar r = 0; r < N; r++) begin : g_lane
            assign w_lane_vld[r] = (r_state == RUN)
                                && (w_cnt32 >= 32'(L + r))
                                && (w_cnt32 <  32'(L + r + K));
            assign w_x[r][0]  = in_x_flat[(r+1)*D_W-1 -: D_W];
            assign w_xv[r][0] = w_lane_vld[r];
            assign w_y[0][r]  = in_y_flat[(r+1)*D_W-1 -: D_W];
            assign w_yv[0][r] = w_lane_vld[r];
        end

        for (genvar i = 0; i < N; i++) begin : g_row
            for (genvar j = 0; j < N; j++) begin : g_col
                pe #(
                    .D_W   (D_W),
                    .ACC_W (ACC_W)
                ) u_pe (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_clr   (w_start),
                    .i_x     (w_x[i][j]),
                    .i_x_vld (w_xv[i][j]),
                    .i_y     (w_y[i][j]),
                    .i_y_vld (w_yv[i][j]),
                    .o_x     (w_x[i][j+1]),
                    .o_x_vld (w_xv[i][j+1]),
                    .o_y     (w_y[i+1][j]),
                    .o_y_vld (w_yv[i+1][j]),
                    .o_acc   (w_acc[i][j])
                );
                assign result_flat[(i*N+j+1)*ACC_W-1 -: ACC_W] = w_acc[i][j];
            end
        end

        // Operands leaving the east and south edges have no consumer.
        for (genvar e = 0; e < N; e++) begin : g_edge
            logic w_unused_edge;
            assign w_unused_edge = ^{w_x[e][N], w_xv[e][N], w_y[N][e], w_yv[N][e]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array
// Description : Randomised self-checking bench for systolic_array against a
//               plain matrix-product reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array;

    localparam int D_W    = 8;
    localparam int N      = 2;
    localparam int K      = 2;
    localparam int L      = 2;
    localparam int ACC_W  = 2*D_W + $clog2(K);
    localparam int DONE_C = L + 2*N + K - 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_init = 1'b0;
    logic [N*D_W-1:0]     in_x_flat = '0;
    logic [N*D_W-1:0]     in_y_flat = '0;
    logic [N*N*ACC_W-1:0] result_flat;
    logic                 busy;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned          ma [N][K];
    int unsigned          mb [K][N];
    logic [N*N*ACC_W-1:0] exp_flat;
    logic [31:0]          obs_done;
    logic [31:0]          obs_busy;
    logic                 pre_done;
    logic [31:0]          exp_done;
    logic [31:0]          exp_busy;

    always #5 clk = ~clk;

    systolic_array #(.D_W(D_W), .N(N), .K(K), .L(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_x_flat   (in_x_flat),
        .in_y_flat   (in_y_flat),
        .in_init     (in_init),
        .result_flat (result_flat),
        .busy        (busy),
        .done        (done)
    );

    function automatic void model();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int unsigned s = 0;
                for (int k = 0; k < K; k++) s += ma[i][k] * mb[k][j];
                exp_flat[(i*N+j+1)*ACC_W-1 -: ACC_W] = ACC_W'(s);
            end
    endfunction

    task automatic set_basic();
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        model();
    endtask

    task automatic drive_lanes(input int c, input bit garbage);
        for (int r = 0; r < N; r++) begin
            int k = c - L - r;
            if (k >= 0 && k < K) begin
                in_x_flat[(r+1)*D_W-1 -: D_W] = D_W'(ma[r][k]);
                in_y_flat[(r+1)*D_W-1 -: D_W] = D_W'(mb[k][r]);
            end else if (garbage) begin
                in_x_flat[(r+1)*D_W-1 -: D_W] = D_W'($urandom);
                in_y_flat[(r+1)*D_W-1 -: D_W] = D_W'($urandom);
            end else begin
                in_x_flat[(r+1)*D_W-1 -: D_W] = '0;
                in_y_flat[(r+1)*D_W-1 -: D_W] = '0;
            end
        end
    endtask

    // Pulses in_init for one cycle, then streams ncyc cycles (cycle c follows
    // edge t0+c) and records done/busy per cycle; optional extra in_init.
    task automatic run_cycles(input int ncyc, input int reinit_at, input bit garbage);
        obs_done = '0;
        obs_busy = '0;
        @(negedge clk);
        pre_done = done;
        in_init  = 1'b1;
        drive_lanes(-1, garbage);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            in_init     = (c == reinit_at);
            drive_lanes(c, garbage);
            obs_done[c] = done;
            obs_busy[c] = busy;
        end
        in_init = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (result_flat !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result_flat); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_basic();
        run_cycles(DONE_C + 1, -1, 1'b0);
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL basic_done_timeline got %b want %b", obs_done, exp_done); end
        n_cmp++; if (obs_busy !== exp_busy) begin n_err++; $display("FAIL basic_busy_timeline got %b want %b", obs_busy, exp_busy); end
        n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL basic_result got %h want %h", result_flat, exp_flat); end
        drive_lanes(-1, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({result_flat, busy, done} !== {exp_flat, 2'b00}) begin
            n_err++; $display("FAIL basic_hold got %h/%b/%b want %h/0/0", result_flat, busy, done, exp_flat);
        end
    endtask

    task automatic test_max();
        for (int i = 0; i < N; i++) for (int k = 0; k < K; k++) begin ma[i][k] = 255; mb[k][i] = 255; end
        exp_flat = {N*N{ACC_W'(130050)}};
        run_cycles(DONE_C + 1, -1, 1'b0);
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL max_done_timeline got %b want %b", obs_done, exp_done); end
        n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL max_result got %h want %h", result_flat, exp_flat); end
    endtask

    task automatic test_ignored_init();
        set_basic();
        // Set during cycle 2 so it is sampled at edge t0+3, mid-run.
        run_cycles(DONE_C + 1, 2, 1'b0);
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL ignored_init_done got %b want %b", obs_done, exp_done); end
        n_cmp++; if (obs_busy !== exp_busy) begin n_err++; $display("FAIL ignored_init_busy got %b want %b", obs_busy, exp_busy); end
        n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL ignored_init_result got %h want %h", result_flat, exp_flat); end
    endtask

    task automatic test_back_to_back();
        set_basic();
        run_cycles(DONE_C, -1, 1'b0);
        ma[0][0] = 1; ma[0][1] = 0; ma[1][0] = 0; ma[1][1] = 1;
        mb[0][0] = 9; mb[0][1] = 8; mb[1][0] = 7; mb[1][1] = 6;
        model();
        run_cycles(DONE_C + 1, -1, 1'b0);
        n_cmp++; if (pre_done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done got %b want 1", pre_done); end
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL b2b_done got %b want %b", obs_done, exp_done); end
        n_cmp++; if (obs_busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy got %b want %b", obs_busy, exp_busy); end
        n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL b2b_result got %h want %h", result_flat, exp_flat); end
    endtask

    task automatic test_reset_midrun();
        logic seen;
        set_basic();
        run_cycles(4, -1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (result_flat !== '0) begin n_err++; $display("FAIL midrst_result got %h want 0", result_flat); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            drive_lanes(-1, 1'b1);
            if (done || busy || (result_flat != '0)) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_after_release got activity=%b want 0", seen); end
    endtask

    task automatic test_garbage();
        set_basic();
        run_cycles(DONE_C + 1, -1, 1'b1);
        n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL garbage_done got %b want %b", obs_done, exp_done); end
        n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL garbage_result got %h want %h", result_flat, exp_flat); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) begin
                    ma[i][k] = $urandom_range(255);
                    mb[k][i] = $urandom_range(255);
                end
            model();
            run_cycles(DONE_C + 1, -1, 1'b1);
            n_cmp++; if (obs_done !== exp_done) begin n_err++; $display("FAIL random%0d_done got %b want %b", t, obs_done, exp_done); end
            n_cmp++; if (result_flat !== exp_flat) begin n_err++; $display("FAIL random%0d_result got %h want %h", t, result_flat, exp_flat); end
        end
    endtask

    initial begin
        exp_done = 32'(1) << DONE_C;
        exp_busy = (32'(1) << DONE_C) - 32'(1);
        test_reset();
        test_basic();
        test_max();
        test_ignored_init();
        test_back_to_back();
        test_reset_midrun();
        test_garbage();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
